// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multicycle RV32I control unit.
// Drives the multicycle datapath (PC, IR, OldPC, A, WriteData, ALUOut, Data)
// from the instruction fields and the ALU flags. It adds a memory ready
// handshake, an illegal-instruction trap state and a retired-instruction counter.
// Outputs are decoded from the state register. The FETCH strobes also follow
// mem_ready, and the BRANCH pc_write also follows the ALU flags.

module mc_ctrl_unit #(
  parameter int MEM_WAIT  = 1,
  parameter int CNT_W     = 32,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [2:0]           imm_src,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_JAL    = 4'd9,
    S_JALR1  = 4'd10,
    S_JALR2  = 4'd11,
    S_LUI    = 4'd12,
    S_AUIPC  = 4'd13,
    S_BRANCH = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] instret_r;
  logic             rdy_s;
  logic             retire_s;
  logic             mem_req_s, pc_write_s, ir_write_s, reg_write_s, mem_write_s, illegal_s;
  logic [3:0]       alu_code_s;

  // ALU operation from funct3/funct7b5; only R-type add can become sub
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && f7b5) ? 4'd1 : 4'd0;
      3'b001:  code = 4'd7;
      3'b010:  code = 4'd5;
      3'b011:  code = 4'd6;
      3'b100:  code = 4'd4;
      3'b101:  code = f7b5 ? 4'd9 : 4'd8;
      3'b110:  code = 4'd3;
      3'b111:  code = 4'd2;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Branch condition from funct3 and the ALU flags of rs1-rs2
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic l, input logic lu);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = l;
      3'b101:  t = ~l;
      3'b110:  t = lu;
      3'b111:  t = ~lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign rdy_s    = (MEM_WAIT == 32'sd0) ? 1'b1 : mem_ready;
  assign retire_s = (state_r == S_MEMWB) || (state_r == S_ALUWB) ||
                    (state_r == S_BRANCH) || ((state_r == S_MEMWR) && rdy_s);

  // State sequencing and retire counting; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= S_FETCH;
      instret_r <= '0;
    end else begin
      if (retire_s) begin
        instret_r <= instret_r + CNT_W'(1'b1);
      end else begin
        instret_r <= instret_r;
      end
      case (state_r)
        S_FETCH:  state_r <= rdy_s ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state_r <= (funct3 == 3'b010) ? S_MEMADR : S_TRAP;
            OP_R:     state_r <= S_EXECR;
            OP_I:     state_r <= S_EXECI;
            OP_JAL:   state_r <= S_JAL;
            OP_JALR:  state_r <= (funct3 == 3'b000) ? S_JALR1 : S_TRAP;
            OP_BR:    state_r <= ((funct3 == 3'b010) || (funct3 == 3'b011)) ? S_TRAP : S_BRANCH;
            OP_LUI:   state_r <= S_LUI;
            OP_AUIPC: state_r <= S_AUIPC;
            default:  state_r <= S_TRAP;
          endcase
        end
        S_MEMADR: state_r <= (op == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_r <= rdy_s ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state_r <= S_FETCH;
        S_MEMWR:  state_r <= rdy_s ? S_FETCH : S_MEMWR;
        S_EXECR:  state_r <= S_ALUWB;
        S_EXECI:  state_r <= S_ALUWB;
        S_ALUWB:  state_r <= S_FETCH;
        S_JAL:    state_r <= S_ALUWB;
        S_JALR1:  state_r <= S_JALR2;
        S_JALR2:  state_r <= S_ALUWB;
        S_LUI:    state_r <= S_ALUWB;
        S_AUIPC:  state_r <= S_ALUWB;
        S_BRANCH: state_r <= S_FETCH;
        S_TRAP:   state_r <= S_TRAP;
        default:  state_r <= S_TRAP;
      endcase
    end
  end

  // Per-state control word; anything not set stays idle (strobes 0, selects 00, add)
  always_comb begin
    mem_req_s   = 1'b0;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_code_s  = 4'd0;
    case (state_r)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        ir_write_s = rdy_s;
        pc_write_s = rdy_s;
        result_src = 2'b10;
        alu_src_b  = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        alu_code_s = alu_decode(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_code_s = alu_decode(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL, S_JALR2: begin
        pc_write_s = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
      end
      S_JALR1: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_code_s = 4'd1;
        pc_write_s = branch_taken(funct3, zero, lt, ltu);
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
      OP_STORE:               imm_src = 3'b001;
      OP_BR:                  imm_src = 3'b010;
      OP_JAL:                 imm_src = 3'b011;
      OP_LUI, OP_AUIPC:       imm_src = 3'b100;
      default:                imm_src = 3'b000;
    endcase
  end

  // Reset low suppresses every side effect immediately, not just at the next edge
  assign mem_req     = reset_n & mem_req_s;
  assign pc_write    = reset_n & pc_write_s;
  assign ir_write    = reset_n & ir_write_s;
  assign reg_write   = reset_n & reg_write_s;
  assign mem_write   = reset_n & mem_write_s;
  assign illegal     = reset_n & illegal_s;
  assign alu_control = ALUCTRL_W'(alu_code_s);
  assign instret     = instret_r;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-cycle vector table on a default instance,
// plus a hand-written sequence on a MEM_WAIT=0 / 2-bit counter instance.

module tb_mc_ctrl_unit;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] AU  = 7'b0010111;
  localparam logic [6:0] ILL = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, funct7b5, zero, lt, ltu, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic mem_req, pc_write, ir_write, reg_write, mem_write, adr_src, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic [2:0] imm_src;
  logic [31:0] instret;

  logic reset_n2, mem_ready2;
  logic mem_req2, pc_write2, ir_write2, reg_write2, mem_write2, adr_src2, illegal2;
  logic [1:0] result_src2, alu_src_a2, alu_src_b2;
  logic [5:0] alu_control2;
  logic [2:0] imm_src2;
  logic [1:0] instret2;

  mc_ctrl_unit dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .adr_src(adr_src), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .illegal(illegal), .instret(instret)
  );

  mc_ctrl_unit #(.MEM_WAIT(0), .CNT_W(2), .ALUCTRL_W(6)) dut2 (
    .clk(clk), .reset_n(reset_n2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .pc_write(pc_write2), .ir_write(ir_write2), .reg_write(reg_write2),
    .mem_write(mem_write2), .adr_src(adr_src2), .result_src(result_src2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_control(alu_control2),
    .imm_src(imm_src2), .illegal(illegal2), .instret(instret2)
  );

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [2:0]  flg;   // {zero, lt, ltu}
    logic        rdy;
    logic [19:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Control word: {mem_req,pc_write,ir_write,reg_write,mem_write,adr_src,
  //                result_src,alu_src_a,alu_src_b,alu_control,imm_src,illegal}
  function automatic logic [19:0] cw(int mr, int pw, int iw, int rw, int mw, int as,
                                     int rs, int sa, int sb, int ac, int im, int il);
    return {mr[0], pw[0], iw[0], rw[0], mw[0], as[0], rs[1:0], sa[1:0], sb[1:0],
            ac[3:0], im[2:0], il[0]};
  endfunction

  // Strobes, mem_req and illegal cleared while reset_n is low
  function automatic logic [19:0] m(logic [19:0] x);
    return x & ~20'hF8001;
  endfunction

  function automatic logic [19:0] fetch(int r, int im); return cw(1,r,r,0,0,0,2,0,2,0,im,0); endfunction
  function automatic logic [19:0] dec(int im);  return cw(0,0,0,0,0,0,0,1,1,0,im,0); endfunction
  function automatic logic [19:0] madr(int im); return cw(0,0,0,0,0,0,0,2,1,0,im,0); endfunction
  function automatic logic [19:0] mrd(int im);  return cw(1,0,0,0,0,1,0,0,0,0,im,0); endfunction
  function automatic logic [19:0] mwb(int im);  return cw(0,0,0,1,0,0,1,0,0,0,im,0); endfunction
  function automatic logic [19:0] mwr(int im);  return cw(1,0,0,0,1,1,0,0,0,0,im,0); endfunction
  function automatic logic [19:0] exr(int ac);  return cw(0,0,0,0,0,0,0,2,0,ac,0,0); endfunction
  function automatic logic [19:0] exi(int ac);  return cw(0,0,0,0,0,0,0,2,1,ac,0,0); endfunction
  function automatic logic [19:0] awb(int im);  return cw(0,0,0,1,0,0,0,0,0,0,im,0); endfunction
  function automatic logic [19:0] br(int pw);   return cw(0,pw,0,0,0,0,0,2,0,1,2,0); endfunction

  task automatic add(input logic rst, input logic [6:0] o, input int f3, input int f7,
                     input int flg, input int rdy, input logic [19:0] ctl, input int cnt);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3[2:0]; v.f7 = f7[0]; v.flg = flg[2:0];
    v.rdy = rdy[0]; v.ctl = ctl; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [19:0] act;
    reset_n = 1'b0; reset_n2 = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0;
    op = R; funct3 = 3'b000; funct7b5 = 1'b0; {zero, lt, ltu} = 3'b000;

    // reset, add, sub
    add(0,R,0,0,0,1,m(fetch(1,0)),0);
    add(1,R,0,0,0,1,fetch(1,0),0);
    add(1,R,0,0,0,1,dec(0),0);
    add(1,R,0,0,0,1,exr(0),0);
    add(1,R,0,0,0,1,awb(0),0);
    add(1,R,0,1,0,1,fetch(1,0),1);
    add(1,R,0,1,0,1,dec(0),1);
    add(1,R,0,1,0,1,exr(1),1);
    add(1,R,0,1,0,1,awb(0),1);
    // reset held 3 cycles mid-EXECR
    add(1,R,0,0,0,1,fetch(1,0),2);
    add(1,R,0,0,0,1,dec(0),2);
    add(0,R,0,0,0,1,m(exr(0)),2);
    add(0,R,0,0,0,1,m(fetch(1,0)),0);
    add(0,R,0,0,0,1,m(fetch(1,0)),0);
    // lw with fetch wait and 3 wait cycles in MEMRD
    add(1,LD,2,0,0,0,fetch(0,0),0);
    add(1,LD,2,0,0,1,fetch(1,0),0);
    add(1,LD,2,0,0,1,dec(0),0);
    add(1,LD,2,0,0,1,madr(0),0);
    add(1,LD,2,0,0,0,mrd(0),0);
    add(1,LD,2,0,0,0,mrd(0),0);
    add(1,LD,2,0,0,0,mrd(0),0);
    add(1,LD,2,0,0,1,mrd(0),0);
    add(1,LD,2,0,0,1,mwb(0),0);
    // sw with one wait cycle
    add(1,ST,2,0,0,1,fetch(1,1),1);
    add(1,ST,2,0,0,1,dec(1),1);
    add(1,ST,2,0,0,1,madr(1),1);
    add(1,ST,2,0,0,0,mwr(1),1);
    add(1,ST,2,0,0,1,mwr(1),1);
    // bge with lt=1 (not taken), bltu with ltu=1 (taken)
    add(1,BR,5,0,3'b010,1,fetch(1,2),2);
    add(1,BR,5,0,3'b010,1,dec(2),2);
    add(1,BR,5,0,3'b010,1,br(0),2);
    add(1,BR,6,0,3'b001,1,fetch(1,2),3);
    add(1,BR,6,0,3'b001,1,dec(2),3);
    add(1,BR,6,0,3'b001,1,br(1),3);
    // jalr
    add(1,JR,0,0,0,1,fetch(1,0),4);
    add(1,JR,0,0,0,1,dec(0),4);
    add(1,JR,0,0,0,1,cw(0,0,0,0,0,0,0,2,1,0,0,0),4);
    add(1,JR,0,0,0,1,cw(0,1,0,0,0,0,0,1,2,0,0,0),4);
    add(1,JR,0,0,0,1,awb(0),4);
    // addi with funct7b5=1 stays add; srai
    add(1,IT,0,1,0,1,fetch(1,0),5);
    add(1,IT,0,1,0,1,dec(0),5);
    add(1,IT,0,1,0,1,exi(0),5);
    add(1,IT,0,1,0,1,awb(0),5);
    add(1,IT,5,1,0,1,fetch(1,0),6);
    add(1,IT,5,1,0,1,dec(0),6);
    add(1,IT,5,1,0,1,exi(9),6);
    add(1,IT,5,1,0,1,awb(0),6);
    // jal, lui, auipc
    add(1,JL,0,0,0,1,fetch(1,3),7);
    add(1,JL,0,0,0,1,dec(3),7);
    add(1,JL,0,0,0,1,cw(0,1,0,0,0,0,0,1,2,0,3,0),7);
    add(1,JL,0,0,0,1,awb(3),7);
    add(1,LU,0,0,0,1,fetch(1,4),8);
    add(1,LU,0,0,0,1,dec(4),8);
    add(1,LU,0,0,0,1,cw(0,0,0,0,0,0,0,3,1,0,4,0),8);
    add(1,LU,0,0,0,1,awb(4),8);
    add(1,AU,0,0,0,1,fetch(1,4),9);
    add(1,AU,0,0,0,1,dec(4),9);
    add(1,AU,0,0,0,1,cw(0,0,0,0,0,0,0,1,1,0,4,0),9);
    add(1,AU,0,0,0,1,awb(4),9);
    // illegal opcode: absorbing trap, counter frozen, reset clears
    add(1,ILL,0,0,0,1,fetch(1,0),10);
    add(1,ILL,0,0,0,1,dec(0),10);
    for (int k = 0; k < 10; k++) add(1,ILL,0,0,0,1,cw(0,0,0,0,0,0,0,0,0,0,0,1),10);
    add(0,ILL,0,0,0,1,20'h00000,10);
    add(0,ILL,0,0,0,1,m(fetch(1,0)),0);
    add(1,R,0,0,0,1,fetch(1,0),0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      reset_n = tbl[i].rst; op = tbl[i].op; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
      {zero, lt, ltu} = tbl[i].flg; mem_ready = tbl[i].rdy;
      @(negedge clk);
      act = {mem_req, pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
             alu_src_a, alu_src_b, alu_control, imm_src, illegal};
      check($sformatf("ctl[%0d]", i), {12'h000, act}, {12'h000, tbl[i].ctl});
      check($sformatf("instret[%0d]", i), instret, tbl[i].cnt);
      @(posedge clk);
      #1;
    end

    // MEM_WAIT=0 instance: sw with mem_ready stuck low, 2-bit counter wraps
    op = ST; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready2 = 1'b0; reset_n2 = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      check($sformatf("w0_instret[%0d]", c), {30'd0, instret2}, (c / 4) % 4);
      if (c == 0) begin
        check("w0_fetch_ir_write", {31'd0, ir_write2}, 32'd1);
        check("w0_alu_upper", {30'd0, alu_control2[5:4]}, 32'd0);
      end
      if (c == 3) begin
        check("w0_memwr_write", {31'd0, mem_write2}, 32'd1);
        check("w0_memwr_adr", {31'd0, adr_src2}, 32'd1);
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
